// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: WIDTH radix-2 steps per operation, Busy stalls the PC.
// Optional MULDIV_FAST_MUL_EN: multiplies complete in one cycle via a combinational product.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Valid,
    output logic [WIDTH-1:0] Result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             negr_q, negr_d;
    logic             nega_q, nega_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Operand decode for the instruction being issued
    logic             is_div;
    logic             a_signed_op, b_signed_op;
    logic             a_sgn, b_sgn;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] special_res;

    always_comb begin
        is_div      = Op[2];
        a_signed_op = (Op == OP_MULH) || (Op == OP_MULHSU) || (Op == OP_DIV) || (Op == OP_REM);
        b_signed_op = (Op == OP_MULH) || (Op == OP_DIV) || (Op == OP_REM);
        a_sgn       = a_signed_op & A[WIDTH-1];
        b_sgn       = b_signed_op & B[WIDTH-1];
        a_mag       = a_sgn ? ('0 - A) : A;
        b_mag       = b_sgn ? ('0 - B) : B;
        div_zero    = is_div && (B == '0);
        div_ovf     = is_div && !Op[0] && (A == MOST_NEG) && (B == '1);
        special_res = '0;
        if (div_zero) begin
            special_res = Op[1] ? A : '1;
        end else if (div_ovf) begin
            special_res = Op[1] ? '0 : A;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [WIDTH:0]     fast_a, fast_b;
    logic signed [2*WIDTH-1:0] fast_prod;
    logic [WIDTH-1:0]          fast_res;

    always_comb begin
        fast_a    = $signed({a_signed_op & A[WIDTH-1], A});
        fast_b    = $signed({b_signed_op & B[WIDTH-1], B});
        fast_prod = fast_a * fast_b;
        fast_res  = (Op == OP_MUL) ? fast_prod[WIDTH-1:0] : fast_prod[2*WIDTH-1:WIDTH];
    end
`endif

    // One radix-2 step on the registered datapath
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh, div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH-1:0]   final_res;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb_q};
        div_ok   = ~div_diff[WIDTH];
        if (op_q[2]) begin
            step_hi = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ok};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        prod     = {step_hi, step_lo};
        prod_fix = negr_q ? ('0 - prod) : prod;
        quo_fix  = negr_q ? ('0 - step_lo) : step_lo;
        rem_fix  = nega_q ? ('0 - step_hi) : step_hi;
        case (op_q)
            OP_MUL:                       final_res = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              final_res = quo_fix;
            default:                      final_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        negr_d   = negr_q;
        nega_d   = nega_q;
        valid_d  = 1'b0;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    op_d   = Op;
                    hi_d   = '0;
                    lo_d   = is_div ? a_mag : b_mag;
                    opb_d  = is_div ? b_mag : a_mag;
                    negr_d = a_sgn ^ b_sgn;
                    nega_d = a_sgn;
                    cnt_d  = CW'(WIDTH);
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
                    end else if (!is_div) begin
                        result_d = fast_res;
                        valid_d  = 1'b1;
                        state_d  = S_DONE;
`endif
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q - CW'(1);
                // Last step: sign-correct straight from the step outputs
                if (cnt_q == CW'(1)) begin
                    result_d = final_res;
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            negr_q   <= 1'b0;
            nega_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            negr_q   <= negr_d;
            nega_q   <= nega_d;
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign Busy   = Reset_n && (((state_q == S_IDLE) && Start) || (state_q == S_RUN));
    assign Valid  = valid_q;
    assign Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized ops vs an arithmetic model.
module tb_muldiv_unit;

    localparam int unsigned W = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic          CLK = 1'b0;
    logic          Reset_n;
    logic          Start;
    logic [2:0]    Op;
    logic [W-1:0]  A, B;
    logic          Busy, Valid;
    logic [W-1:0]  Result;

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .Reset_n(Reset_n),
        .Start  (Start),
        .Op     (Op),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .Valid  (Valid),
        .Result (Result)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, ub;
        logic [63:0] p;
        int ia, ib;
        logic ovf;
        sa  = $signed({{32{a[31]}}, a});
        sb  = $signed({{32{b[31]}}, b});
        ub  = $signed({32'b0, b});
        ia  = a;
        ib  = b;
        ovf = (a == MIN_NEG) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_busy(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0)) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return W + 1;
    endfunction

    // Issue one op at a negedge and hold Start until Valid; operands are scrambled after issue.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit idle_after);
        int busy_n;
        bit seen;
        logic [31:0] exp;
        exp    = ref_model(op, a, b);
        busy_n = 0;
        seen   = 1'b0;
        @(negedge CLK);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        for (int c = 0; c < int'(W) + 8; c++) begin
            #1;
            if (Valid) begin
                seen = 1'b1;
                break;
            end
            if (Busy) busy_n++;
            @(negedge CLK);
            A  = $urandom;
            B  = $urandom;
            Op = 3'($urandom_range(0, 7));
        end
        check_eq($sformatf("valid_seen op%0d", op), 64'(seen), 64'd1);
        check_eq($sformatf("busy_cycles op%0d", op), 64'(busy_n), 64'(exp_busy(op, a, b)));
        check_eq("busy_low_in_done", 64'(Busy), 64'd0);
        check_eq($sformatf("result op%0d a=%0h b=%0h", op, a, b), 64'(Result), 64'(exp));
        if (idle_after) begin
            @(negedge CLK);
            Start = 1'b0;
            #1;
            check_eq("valid_one_cycle", 64'(Valid), 64'd0);
            check_eq("no_retrigger", 64'(Busy), 64'd0);
            check_eq("result_hold", 64'(Result), 64'(exp));
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return MIN_NEG;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int vcount;
        int bcount;
        Reset_n = 1'b0;
        Start   = 1'b1;
        Op      = 3'd0;
        A       = 32'd7;
        B       = 32'd3;
        #1;
        check_eq("reset_busy", 64'(Busy), 64'd0);
        check_eq("reset_valid", 64'(Valid), 64'd0);
        check_eq("reset_result", 64'(Result), 64'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Start   = 1'b0;
        Reset_n = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op(3'd5, 32'd100, 32'd7, 1'b1);
        run_op(3'd7, 32'd100, 32'd7, 1'b1);
        run_op(3'd5, 32'h1234, 32'd0, 1'b1);
        run_op(3'd6, 32'h1234, 32'd0, 1'b1);
        run_op(3'd4, MIN_NEG, 32'hFFFF_FFFF, 1'b1);
        run_op(3'd6, MIN_NEG, 32'hFFFF_FFFF, 1'b1);
        run_op(3'd1, MIN_NEG, MIN_NEG, 1'b1);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

        run_op(3'd5, 32'd9, 32'd3, 1'b0);
        run_op(3'd0, 32'd3, 32'd5, 1'b1);

        // Abort a DIV mid-run with a one-cycle reset
        @(negedge CLK);
        Start = 1'b1;
        Op    = 3'd4;
        A     = 32'hFFFF_FF9C;
        B     = 32'd7;
        repeat (10) @(negedge CLK);
        Reset_n = 1'b0;
        #1;
        check_eq("abort_busy", 64'(Busy), 64'd0);
        check_eq("abort_valid", 64'(Valid), 64'd0);
        check_eq("abort_result", 64'(Result), 64'd0);
        @(negedge CLK);
        Reset_n = 1'b1;
        Start   = 1'b0;
        vcount  = 0;
        bcount  = 0;
        for (int c = 0; c < int'(W) + 4; c++) begin
            #1;
            if (Valid) vcount++;
            if (Busy) bcount++;
            @(negedge CLK);
        end
        check_eq("abort_no_valid", 64'(vcount), 64'd0);
        check_eq("abort_idle", 64'(bcount), 64'd0);
        run_op(3'd5, 32'd10, 32'd3, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                   1'($urandom_range(0, 1)));
        end
        @(negedge CLK);
        Start = 1'b0;
        repeat (2) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
